// File: rtl/uart_rx_pkg.sv
// Shared constants and types for the parametrised UART receiver.
package uart_rx_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  // Each FIFO entry is {frame_err, parity_err, data}.
  localparam int ERR_W          = 2;
  localparam int FRAME_ERR_BIT  = 1;
  localparam int PARITY_ERR_BIT = 0;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } rx_state_t;

  typedef enum logic {
    C_IDLE,
    C_WAIT
  } call_state_t;

  function automatic int entry_w(input int data_bits);
    return data_bits + ERR_W;
  endfunction

endpackage

// File: rtl/uart_rx_param_if.sv
// Accelerator call interface: start/finish handshake with returned frame and status.
interface uart_rx_param_if
  import uart_rx_pkg::*;
#(
  parameter int DATA_BITS = 8
);
  logic                 start;
  logic                 finish;
  logic [DATA_BITS-1:0] return_val;
  logic [ERR_W-1:0]     rx_err;
  logic                 overrun;
  logic                 clear_overrun;

  modport master (
    output start, clear_overrun,
    input  finish, return_val, rx_err, overrun
  );

  modport slave (
    input  start, clear_overrun,
    output finish, return_val, rx_err, overrun
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// Small frame buffer with registered read data; full and pop in one cycle both succeed.
module uart_rx_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      rd_data <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop) begin
        rd_ptr  <= rd_ptr + (AW+1)'(1);
        rd_data <= mem[rd_ptr[AW-1:0]];
      end
    end
  end
endmodule

// File: rtl/uart_rx_param.sv
// UART receiver with frame FIFO, served one frame per start/finish accelerator call.
module uart_rx_param
  import uart_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 564,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = PAR_NONE,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic           clk,
  input  logic           reset,
  uart_rx_param_if.slave bus,
  input  logic           UART_RXD
);
  localparam int CNT_W   = $clog2(CLKS_PER_BIT);
  localparam int IDX_W   = $clog2(DATA_BITS);
  localparam int HALF    = CLKS_PER_BIT / 2;
  localparam int ENTRY_W = entry_w(DATA_BITS);
  localparam logic [CNT_W-1:0] CNT_MID    = CNT_W'(HALF - 1);
  localparam logic [CNT_W-1:0] CNT_FULL   = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(DATA_BITS - 1);
  localparam logic             PAR_EXPECT = (PARITY == PAR_ODD);

  logic                 rxd_p0, rxd_p1, rxd_prev;
  rx_state_t            rx_state;
  logic [CNT_W-1:0]     cnt;
  logic [IDX_W-1:0]     bit_idx;
  logic                 stop_idx;
  logic                 frame_err, parity_err;
  logic [DATA_BITS-1:0] shreg;
  logic                 bit_tick;
  call_state_t          call_state;
  logic                 finish_r, overrun_r;
  logic                 push, pop, fifo_full, fifo_empty;
  logic [ENTRY_W-1:0]   push_data, rd_data;

  // Stage p0/p1: two-flop synchronizer; rxd_prev feeds falling-edge detection.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rxd_p0   <= 1'b1;
      rxd_p1   <= 1'b1;
      rxd_prev <= 1'b1;
    end else begin
      rxd_p0   <= UART_RXD;
      rxd_p1   <= rxd_p0;
      rxd_prev <= rxd_p1;
    end
  end

  assign bit_tick  = (cnt == CNT_FULL);
  assign push      = (rx_state == RX_STOP) && bit_tick && (stop_idx == 1'(STOP_BITS - 1));
  // The last stop sample is folded in here because it lands in the same cycle as the push.
  assign push_data = {frame_err | ~rxd_p1, parity_err, shreg};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_state   <= RX_IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      stop_idx   <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      case (rx_state)
        RX_IDLE: if (rxd_prev && !rxd_p1) begin
          cnt        <= '0;
          frame_err  <= 1'b0;
          parity_err <= 1'b0;
          rx_state   <= RX_START;
        end
        RX_START: if (cnt == CNT_MID) begin
          if (!rxd_p1) begin
            cnt      <= '0;
            bit_idx  <= '0;
            stop_idx <= 1'b0;
            rx_state <= RX_DATA;
          end else begin
            rx_state <= RX_IDLE;
          end
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
        RX_DATA: if (bit_tick) begin
          cnt <= '0;
          if (bit_idx == IDX_LAST) rx_state <= (PARITY != PAR_NONE) ? RX_PARITY : RX_STOP;
          else bit_idx <= bit_idx + IDX_W'(1);
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
        RX_PARITY: if (bit_tick) begin
          cnt        <= '0;
          parity_err <= ((^shreg) ^ rxd_p1) != PAR_EXPECT;
          rx_state   <= RX_STOP;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
        RX_STOP: if (bit_tick) begin
          cnt <= '0;
          if (!rxd_p1) frame_err <= 1'b1;
          if (push) rx_state <= RX_IDLE;
          else stop_idx <= stop_idx + 1'b1;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

  // LSB arrives first, so each sample enters at the MSB and shifts down.
  always_ff @(posedge clk) begin
    if (rx_state == RX_DATA && bit_tick) shreg <= {rxd_p1, shreg[DATA_BITS-1:1]};
  end

  uart_rx_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (push),
    .wr_data (push_data),
    .pop     (pop),
    .rd_data (rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign pop = !finish_r && !fifo_empty && ((call_state == C_WAIT) || bus.start);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      call_state <= C_IDLE;
      finish_r   <= 1'b0;
      overrun_r  <= 1'b0;
    end else begin
      finish_r <= pop;
      if (pop) call_state <= C_IDLE;
      else if (call_state == C_IDLE && bus.start && !finish_r) call_state <= C_WAIT;
      if (push && fifo_full && !pop) overrun_r <= 1'b1;
      else if (bus.clear_overrun) overrun_r <= 1'b0;
    end
  end

  // The FIFO read register holds the last popped frame until the next pop.
  assign bus.finish     = finish_r;
  assign bus.return_val = rd_data[DATA_BITS-1:0];
  assign bus.rx_err     = rd_data[ENTRY_W-1 -: ERR_W];
  assign bus.overrun    = overrun_r;
endmodule

// File: tb/tb_uart_rx_param.sv
// Scoreboard bench for uart_rx_param: an 8N1 instance and an 8E2 instance, bit period 16.
module tb_uart_rx_param;
  localparam int CPB = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;
  logic rxd0, rxd1;

  uart_rx_param_if #(.DATA_BITS(8)) bus0 ();
  uart_rx_param_if #(.DATA_BITS(8)) bus1 ();

  uart_rx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) dut0 (
    .clk(clk), .reset(reset), .bus(bus0), .UART_RXD(rxd0));
  uart_rx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(2), .STOP_BITS(2), .FIFO_DEPTH(4)) dut1 (
    .clk(clk), .reset(reset), .bus(bus1), .UART_RXD(rxd1));

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  logic [9:0]  exp0[$], exp1[$];
  logic [9:0]  mfifo0[$], mfifo1[$];
  bit          pend0 = 0, pend1 = 0, ovr0_exp = 0;
  logic        fin0_d = 0, fin1_d = 0;
  logic [9:0]  e0, e1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  // Reference: the entry a receiver must report for the levels actually put on the line.
  function automatic logic [9:0] ref_entry(input int pmode, input logic [7:0] data, input logic pbit,
                                           input logic [1:0] stops, input int nstop);
    int   ones;
    logic perr, ferr;
    ones = $countones(data) + int'(pbit);
    perr = 1'b0;
    ferr = 1'b0;
    if (pmode == 1) perr = (ones % 2) != 1;
    if (pmode == 2) perr = (ones % 2) != 0;
    for (int i = 0; i < nstop; i++) if (!stops[i]) ferr = 1'b1;
    return {ferr, perr, data};
  endfunction

  task automatic model_arrive(input int which, input logic [9:0] e);
    if (which == 0) begin
      if (pend0) begin exp0.push_back(e); pend0 = 0; end
      else if (mfifo0.size() == 4) ovr0_exp = 1;
      else mfifo0.push_back(e);
    end else begin
      if (pend1) begin exp1.push_back(e); pend1 = 0; end
      else if (mfifo1.size() < 4) mfifo1.push_back(e);
    end
  endtask

  task automatic model_call(input int which);
    if (which == 0) begin
      if (mfifo0.size() > 0) exp0.push_back(mfifo0.pop_front());
      else pend0 = 1;
    end else begin
      if (mfifo1.size() > 0) exp1.push_back(mfifo1.pop_front());
      else pend1 = 1;
    end
  endtask

  task automatic set_line(input int which, input logic v);
    if (which == 0) rxd0 = v;
    else rxd1 = v;
  endtask

  task automatic bit_time(input int which, input logic v);
    set_line(which, v);
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send(input int which, input int pmode, input int nstop, input logic [7:0] data,
                      input logic pbit, input logic [1:0] stops);
    model_arrive(which, ref_entry(pmode, data, pbit, stops, nstop));
    bit_time(which, 1'b0);
    for (int i = 0; i < 8; i++) bit_time(which, data[i]);
    if (pmode != 0) bit_time(which, pbit);
    for (int i = 0; i < nstop; i++) bit_time(which, stops[i]);
    set_line(which, 1'b1);
    repeat (2 * CPB) @(negedge clk);
  endtask

  task automatic call(input int which, input bit check_lat);
    model_call(which);
    if (which == 0) bus0.start = 1'b1;
    else bus1.start = 1'b1;
    @(negedge clk);
    if (check_lat) check("call_latency", (which == 0) ? bus0.finish : bus1.finish, 1);
    bus0.start = 1'b0;
    bus1.start = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_drain(input int which);
    int t;
    t = 0;
    while (((which == 0) ? exp0.size() : exp1.size()) != 0 && t < 4000) begin
      @(negedge clk);
      t++;
    end
    n_vec++;
    if (t >= 4000) begin
      n_err++;
      $display("FAIL drain_timeout: dut%0d still owes %0d frames, required 0", which,
               (which == 0) ? exp0.size() : exp1.size());
    end
  endtask

  always @(negedge clk) begin
    if (bus0.finish) begin
      n_vec++;
      if (fin0_d) begin
        n_err++;
        $display("FAIL dut0_finish_twice: finish high 2 cycles, required single pulse");
      end else if (exp0.size() == 0) begin
        n_err++;
        $display("FAIL dut0_unexpected_finish: got %0h, required no finish", {bus0.rx_err, bus0.return_val});
      end else begin
        e0 = exp0.pop_front();
        if ({bus0.rx_err, bus0.return_val} !== e0) begin
          n_err++;
          $display("FAIL dut0_frame: got %0h required %0h", {bus0.rx_err, bus0.return_val}, e0);
        end
      end
    end
    if (bus1.finish) begin
      n_vec++;
      if (fin1_d) begin
        n_err++;
        $display("FAIL dut1_finish_twice: finish high 2 cycles, required single pulse");
      end else if (exp1.size() == 0) begin
        n_err++;
        $display("FAIL dut1_unexpected_finish: got %0h, required no finish", {bus1.rx_err, bus1.return_val});
      end else begin
        e1 = exp1.pop_front();
        if ({bus1.rx_err, bus1.return_val} !== e1) begin
          n_err++;
          $display("FAIL dut1_frame: got %0h required %0h", {bus1.rx_err, bus1.return_val}, e1);
        end
      end
    end
    fin0_d = bus0.finish;
    fin1_d = bus1.finish;
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    rxd0 = 1'b1;
    rxd1 = 1'b1;
    bus0.start = 1'b0; bus0.clear_overrun = 1'b0;
    bus1.start = 1'b0; bus1.clear_overrun = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_finish", bus0.finish, 0);
    check("reset_return_val", bus0.return_val, 0);
    check("reset_rx_err", bus0.rx_err, 0);
    check("reset_overrun", bus0.overrun, 0);
    check("reset_finish1", bus1.finish, 0);
    reset = 1'b0;
    @(negedge clk);

    // 8N1 0xA5 with start held throughout
    bus0.start = 1'b1;
    model_call(0);
    send(0, 0, 1, 8'hA5, 1'b0, 2'b11);
    model_call(0);
    check("a5_overrun", bus0.overrun, ovr0_exp);

    // Short low glitch must not produce a frame, even with start held
    set_line(0, 1'b0);
    repeat (4) @(negedge clk);
    set_line(0, 1'b1);
    repeat (20 * CPB) @(negedge clk);
    bus0.start = 1'b0;
    check("glitch_fifo_empty", dut0.fifo_empty, 1);

    // Break: line low for 20 bit times, then a clean frame
    model_arrive(0, ref_entry(0, 8'h00, 1'b0, 2'b00, 1));
    set_line(0, 1'b0);
    repeat (20 * CPB) @(negedge clk);
    set_line(0, 1'b1);
    repeat (2 * CPB) @(negedge clk);
    wait_drain(0);
    send(0, 0, 1, 8'h5A, 1'b0, 2'b11);
    call(0, 1);
    wait_drain(0);

    for (int k = 0; k < 6; k++) begin
      logic [7:0] d;
      logic       s;
      d = 8'($urandom_range(0, 255));
      s = ($urandom_range(0, 3) != 0);
      send(0, 0, 1, d, 1'b0, {1'b1, s});
      call(0, 1);
      wait_drain(0);
    end

    // Parity-even, two stop bits
    send(1, 2, 2, 8'h03, 1'b1, 2'b11);
    call(1, 1);
    wait_drain(1);
    send(1, 2, 2, 8'h03, 1'b0, 2'b11);
    call(1, 1);
    wait_drain(1);
    send(1, 2, 2, 8'h81, 1'b0, 2'b01);
    call(1, 1);
    wait_drain(1);
    for (int k = 0; k < 6; k++) begin
      logic [7:0] d;
      logic       p;
      logic [1:0] s;
      d = 8'($urandom_range(0, 255));
      p = 1'($urandom_range(0, 1));
      s = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(0, 3)) : 2'b11;
      send(1, 2, 2, d, p, s);
      call(1, 1);
      wait_drain(1);
    end

    // Overflow: five frames into a four-entry FIFO with no calls
    for (int b = 1; b <= 5; b++) send(0, 0, 1, 8'(b), 1'b0, 2'b11);
    check("overflow_overrun", bus0.overrun, ovr0_exp);
    for (int k = 0; k < 4; k++) call(0, 1);
    wait_drain(0);
    call(0, 0);
    repeat (10) @(negedge clk);
    check("wait_no_finish", bus0.finish, 0);
    bus0.clear_overrun = 1'b1;
    @(negedge clk);
    bus0.clear_overrun = 1'b0;
    ovr0_exp = 0;
    check("clear_overrun", bus0.overrun, ovr0_exp);

    // Reset in the middle of the data bits of 0xFF
    set_line(0, 1'b0);
    repeat (CPB) @(negedge clk);
    set_line(0, 1'b1);
    repeat (3 * CPB) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("midreset_finish", bus0.finish, 0);
    check("midreset_return_val", bus0.return_val, 0);
    check("midreset_rx_err", bus0.rx_err, 0);
    check("midreset_overrun", bus0.overrun, 0);
    check("midreset_fifo_empty", dut0.fifo_empty, 1);
    mfifo0.delete();
    pend0 = 0;
    ovr0_exp = 0;
    @(negedge clk);
    reset = 1'b0;
    repeat (3 * CPB) @(negedge clk);
    check("postreset_fifo_empty", dut0.fifo_empty, 1);
    send(0, 0, 1, 8'h3C, 1'b0, 2'b11);
    call(0, 1);
    wait_drain(0);

    repeat (5) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/uart_rx_param.md
Name: uart_rx_param

Overview:
Parametrised UART receiver for custom-Verilog accelerator calls, using the start/finish/return_val call interface. Data width, parity, stop bits and bit period are configurable. Received frames, with their error flags, are buffered in a small FIFO, so bytes arriving between calls are not lost. Each call pops one frame.

Parameters:
CLKS_PER_BIT, 564, clk cycles per bit (564 = 115200 baud at 65 MHz); must be >= 4
DATA_BITS, 8, data bits per frame, 5..9, LSB first
PARITY, 0, 0 = none, 1 = odd, 2 = even
STOP_BITS, 1, 1 or 2
FIFO_DEPTH, 4, frame buffer entries; power of 2, >= 2

Ports:
clk  in  1  system clock
reset  in  1  async active-high reset
start  in  1  call request; sampled every cycle
finish  out  1  one-cycle pulse; return_val and rx_err valid in that cycle and held until the next finish
return_val  out  DATA_BITS  received data
rx_err  out  2  {frame_err, parity_err} of the returned frame
overrun  out  1  sticky; a frame was dropped because the FIFO was full
clear_overrun  in  1  synchronous clear of overrun
UART_RXD  in  1  asynchronous serial input

Behaviour:
- Interface: reset reset, asynchronous, active-high; clock clk.
- Reset values:
  - all outputs 0
  - both sync flops and the previous-level register 1 (line idle)
  - both FSMs in idle; FIFO empty; counters 0
- Reset mid-frame abandons the frame; no partial push.
- Input sync: 2-flop synchronizer. All sampling uses the synced signal; no latency compensation.
- Counter: width CNT_W = $clog2(CLKS_PER_BIT). HALF = CLKS_PER_BIT/2, floor.
- RX FSM states: RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP.
  - RX_IDLE: a high-to-low transition of the synced line (prev=1, cur=0) sets cnt=0 and goes to RX_START. A line held low never retriggers.
  - RX_START: at cnt==HALF-1, sample the line.
    - Low: cnt=0, bit_idx=0, go to RX_DATA.
    - High: glitch; go to RX_IDLE.
    - Otherwise cnt++.
  - RX_DATA: at cnt==CLKS_PER_BIT-1, shift the sample in at the MSB (LSB-first assembly) and set cnt=0. After DATA_BITS samples go to RX_PARITY if PARITY!=0, else RX_STOP.
  - RX_PARITY: sample at full period. parity_err = (XOR of data ^ parity bit) != expected; expected is 1 for odd, 0 for even.
  - RX_STOP: sample at full period, STOP_BITS times. Any low stop sample sets frame_err.
    - On the last stop sample, push {frame_err, parity_err, data} and go to RX_IDLE.
    - Leaving RX_STOP at mid-bit is intentional; the next start edge is detected normally.
- FIFO: push on the last stop sample.
  - Push when full and no pop in the same cycle: frame dropped, overrun<=1.
  - Push and pop in the same cycle when full: both succeed.
  - No empty-bypass: a pushed entry is poppable from the next cycle.
  - overrun set and clear_overrun in the same cycle: set wins.
- Call FSM states: C_IDLE, C_WAIT.
  - C_IDLE, start=1, FIFO not empty: pop; finish=1 next cycle with return_val and rx_err loaded (latency 1).
  - C_IDLE, start=1, FIFO empty: go to C_WAIT.
  - C_WAIT: on the first cycle the FIFO is not empty, pop; finish next cycle; go to C_IDLE.
  - start while in C_WAIT, or in the cycle finish is high, is ignored.
  - finish is never high for two consecutive cycles.

Decomposition:
- Package uart_rx_pkg holds:
  - parity mode constants PAR_NONE/PAR_ODD/PAR_EVEN
  - rx_state_t and call_state_t enums
  - frame-entry field widths
- Sub-module uart_rx_fifo (params WIDTH, DEPTH): push/pop/full/empty, registered read data, pointers of width $clog2(DEPTH)+1.
- The top level contains the synchronizer, the RX FSM and the call FSM.

Test Plan:
All scenarios use CLKS_PER_BIT=16.
- 8N1, start held from t0, line sends 0xA5 -> exactly one finish pulse; return_val=0xA5, rx_err=00, overrun=0.
- 4-cycle low glitch on an idle line -> no push; FIFO empty; no finish while start held for 20 bit times.
- PARITY=2, 0x03 sent with parity bit 1 -> return_val=0x03, rx_err=01. Same byte with parity bit 0 -> rx_err=00.
- 8N1 break: line held low for 20 bit times, then high -> exactly one frame, return_val=0x00, rx_err=10. A following 0x5A is received clean.
- FIFO_DEPTH=4, frames 0x01..0x05 sent with no start -> overrun=1. Four calls return 01,02,03,04 at latency 1. Fifth call waits in C_WAIT. clear_overrun pulse -> overrun=0.
- Reset asserted mid-RX_DATA of 0xFF -> all outputs 0 immediately, FIFO empty. Next 0x3C received correctly with rx_err=00.
